// File: rtl/sig_logic_array_if.sv
// Pin-side bundle of sig_logic_array: input pins, function select, counter
// control, and the registered outputs and edge counts.
interface sig_logic_array_if #(
   parameter int CH    = 4,
   parameter int CNT_W = 16
);
   logic [2*CH-1:0]     sig_in;
   logic [3*CH-1:0]     mode;
   logic                mode_load;
   logic                cnt_clr;
   logic [CH-1:0]       sig_out;
   logic [CH*CNT_W-1:0] edge_cnt;

   modport master (
      output sig_in, mode, mode_load, cnt_clr,
      input  sig_out, edge_cnt
   );

   modport slave (
      input  sig_in, mode, mode_load, cnt_clr,
      output sig_out, edge_cnt
   );
endinterface

// File: rtl/sig_logic_array.sv
// CH two-input logic channels: synchroniser, glitch filter, selectable
// function, registered output and saturating rising-edge counter per channel.
module sig_logic_array #(
   parameter int CH       = 4,
   parameter int FILT_LEN = 8,
   parameter int FILT_W   = 4,
   parameter int CNT_W    = 16
) (
   input logic             sys_clock,
   input logic             reset,
   sig_logic_array_if.slave bus
);

   localparam int                NB      = 2 * CH;
   localparam logic [FILT_W-1:0] FILT_TC = FILT_W'(FILT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   logic [NB-1:0]       s1;
   logic [NB-1:0]       s2;
   logic [NB-1:0]       f;
   logic [FILT_W-1:0]   c [NB];
   logic [3*CH-1:0]     mode_q;
   logic [CH-1:0]       out_q;
   logic [CH-1:0]       prev;
   logic [CH-1:0]       fn;
   logic [CNT_W-1:0]    cnt [CH];
   logic [CH*CNT_W-1:0] cnt_flat;

   always_comb begin
      fn = '0;
      for (int i = 0; i < CH; i++) begin
         case (mode_q[3*i +: 3])
            3'b000:  fn[i] = ~(f[2*i] & f[2*i+1]);
            3'b001:  fn[i] = f[2*i] & f[2*i+1];
            3'b010:  fn[i] = f[2*i] | f[2*i+1];
            3'b011:  fn[i] = ~(f[2*i] | f[2*i+1]);
            3'b100:  fn[i] = f[2*i] ^ f[2*i+1];
            3'b101:  fn[i] = ~(f[2*i] ^ f[2*i+1]);
            3'b110:  fn[i] = f[2*i];
            default: fn[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         s1     <= '0;
         s2     <= '0;
         f      <= '0;
         mode_q <= '0;
         // All-ones equals NAND(0,0), so leaving reset produces no edge.
         out_q  <= '1;
         prev   <= '1;
         for (int b = 0; b < NB; b++) c[b] <= '0;
         for (int i = 0; i < CH; i++) cnt[i] <= '0;
      end else begin
         s1 <= bus.sig_in;
         s2 <= s1;
         for (int b = 0; b < NB; b++) begin
            if (s2[b] == f[b]) begin
               c[b] <= '0;
            end else if (c[b] == FILT_TC) begin
               f[b] <= s2[b];
               c[b] <= '0;
            end else begin
               c[b] <= c[b] + 1'b1;
            end
         end
         if (bus.mode_load) mode_q <= bus.mode;
         out_q <= fn;
         prev  <= out_q;
         // Clear wins over a coincident edge; that edge is not counted.
         for (int i = 0; i < CH; i++) begin
            if (bus.cnt_clr)
               cnt[i] <= '0;
            else if (out_q[i] && !prev[i] && cnt[i] != CNT_MAX)
               cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      cnt_flat = '0;
      for (int i = 0; i < CH; i++) cnt_flat[CNT_W*i +: CNT_W] = cnt[i];
   end

   assign bus.sig_out  = out_q;
   assign bus.edge_cnt = cnt_flat;

endmodule

// File: tb/tb_sig_logic_array.sv
// Scoreboard bench for sig_logic_array: a per-cycle reference model queues the
// expected outputs, and an independent monitor compares them after each edge.
module tb_sig_logic_array;
   localparam int CH       = 4;
   localparam int FILT_LEN = 8;
   localparam int FILT_W   = 4;
   localparam int CNT_W    = 3;
   localparam int NB       = 2 * CH;
   localparam int CMAX     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;

   sig_logic_array_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

   sig_logic_array #(.CH(CH), .FILT_LEN(FILT_LEN), .FILT_W(FILT_W), .CNT_W(CNT_W)) dut (
      .sys_clock(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0]       out;
      logic [CH*CNT_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: pipeline stages, acceptance history, truth tables.
   logic [NB-1:0]   m_s1, m_s2, m_f;
   bit              hist [NB][$];
   logic [3*CH-1:0] m_mode;
   logic [CH-1:0]   m_out, m_prev;
   int              m_cnt [CH];
   logic [3:0]      tt [8];
   logic [3*CH-1:0] mode_cur;

   initial begin
      // Indexed by {B, A}.
      tt[0] = 4'b0111; tt[1] = 4'b1000; tt[2] = 4'b1110; tt[3] = 4'b0001;
      tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b1010; tt[7] = 4'b0000;
   end

   task automatic model_edge(input logic [NB-1:0] si, input logic [3*CH-1:0] md,
                             input logic ml, input logic cc, input logic rst);
      logic [CH-1:0] n_out;
      logic [NB-1:0] n_f;
      exp_t          e;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_f = '0; m_mode = '0;
         m_out = '1; m_prev = '1;
         for (int b = 0; b < NB; b++) hist[b].delete();
         for (int i = 0; i < CH; i++) m_cnt[i] = 0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            logic [2:0] code;
            code     = m_mode[3*i +: 3];
            n_out[i] = tt[code][{m_f[2*i+1], m_f[2*i]}];
         end
         n_f = m_f;
         for (int b = 0; b < NB; b++) begin
            bit all_same;
            hist[b].push_back(m_s2[b]);
            if (hist[b].size() > FILT_LEN) void'(hist[b].pop_front());
            all_same = (hist[b].size() == FILT_LEN);
            foreach (hist[b][k]) if (hist[b][k] != m_s2[b]) all_same = 0;
            if (all_same && m_s2[b] != m_f[b]) n_f[b] = m_s2[b];
         end
         for (int i = 0; i < CH; i++) begin
            if (cc) m_cnt[i] = 0;
            else if (m_out[i] && !m_prev[i] && m_cnt[i] < CMAX) m_cnt[i]++;
         end
         m_prev = m_out;
         m_out  = n_out;
         m_f    = n_f;
         m_s2   = m_s1;
         m_s1   = si;
         if (ml) m_mode = md;
      end
      e.out = m_out;
      e.cnt = '0;
      for (int i = 0; i < CH; i++) e.cnt[CNT_W*i +: CNT_W] = CNT_W'(m_cnt[i]);
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [NB-1:0] si, input logic [3*CH-1:0] md,
                       input logic ml, input logic cc, input logic rst);
      @(negedge clk);
      bus.sig_in    = si;
      bus.mode      = md;
      bus.mode_load = ml;
      bus.cnt_clr   = cc;
      reset         = rst;
      model_edge(si, md, ml, cc, rst);
   endtask

   task automatic hold(input logic [NB-1:0] si, input int n);
      for (int k = 0; k < n; k++) step(si, mode_cur, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load_mode(input logic [NB-1:0] si, input logic [3*CH-1:0] md);
      mode_cur = md;
      step(si, md, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: one expected entry per clock edge, compared just after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.sig_out !== e.out) begin
               errors++;
               $display("FAIL sig_out at %0t: got %b expected %b", $time, bus.sig_out, e.out);
            end
            checks++;
            if (bus.edge_cnt !== e.cnt) begin
               errors++;
               $display("FAIL edge_cnt at %0t: got %h expected %h", $time, bus.edge_cnt, e.cnt);
            end
         end
      end
   end

   initial begin
      int wait_cyc;
      reset         = 1'b1;
      bus.sig_in    = '0;
      bus.mode      = '0;
      bus.mode_load = 1'b0;
      bus.cnt_clr   = 1'b0;
      mode_cur      = '0;

      // Reset with noisy inputs and strobes that must be ignored.
      for (int k = 0; k < 3; k++)
         step(NB'($urandom), 12'o7777, 1'b1, 1'b1, 1'b1);
      hold(8'h00, 12);

      // Default NAND and input latency.
      hold(8'h0F, 14);
      hold(8'h00, 14);

      // Glitch rejection on channel 0: 7-cycle pulse dropped, 8-cycle accepted.
      hold(8'h03, 7);
      hold(8'h00, 14);
      hold(8'h03, 8);
      hold(8'h00, 14);

      // Mode change to XOR everywhere, then force-0 on channel 0.
      hold(8'h01, 12);
      load_mode(8'h01, 12'o4444);
      hold(8'h01, 4);
      load_mode(8'h01, 12'o4447);
      for (int k = 0; k < 6; k++) hold(NB'($urandom), 10);

      // Saturation: channel 0 follows A via XOR with B low.
      load_mode(8'h00, 12'o0004);
      hold(8'h00, 12);
      step(8'h00, mode_cur, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         hold(8'h01, 12);
         hold(8'h00, 12);
      end

      // Clear coincident with a pending rising edge on channel 0.
      for (int k = 0; k < 20; k++)
         step(8'h01, mode_cur, 1'b0, m_out[0] & ~m_prev[0], 1'b0);
      hold(8'h00, 12);

      // Reset in the middle of a filter window.
      hold(8'h03, 7);
      step(8'h03, mode_cur, 1'b0, 1'b0, 1'b1);
      hold(8'h03, 14);
      hold(8'h00, 14);

      // Randomised traffic.
      for (int seg = 0; seg < 60; seg++) begin
         logic [NB-1:0] si;
         int            len;
         si  = NB'($urandom);
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++) begin
            logic ml, cc, rst;
            ml  = ($urandom_range(0, 19) == 0);
            cc  = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 99) == 0);
            if (ml) mode_cur = (3*CH)'($urandom);
            step(si, mode_cur, ml, cc, rst);
         end
      end
      hold(8'h00, 4);

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
